// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and default sizing for the sequential multiplier.
package mult_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 5;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;
endpackage

// File: rtl/shift_add_datapath.sv
// shift_add_datapath: accumulator, shifting multiplicand and multiplier for shift-and-add.
module shift_add_datapath #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] acc_nxt_o
);
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;

    // acc_nxt_o includes the current step's add so the top can capture the final sum
    always_comb begin
        acc_nxt_o = mplier_q[0] ? acc_q + mcand_q : acc_q;
        acc_d     = load_i ? '0 : step_i ? acc_nxt_o : acc_q;
        mcand_d   = load_i ? {{WIDTH{1'b0}}, a_i} : step_i ? mcand_q << 1 : mcand_q;
        mplier_d  = load_i ? b_i : step_i ? mplier_q >> 1 : mplier_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: fixed-latency unsigned shift-and-add multiplier with a one-cycle done strobe.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH-1:0] product_q, product_d, acc_nxt;
    logic               busy_q, done_q, load, step;

    shift_add_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .step_i    (step),
        .a_i       (a),
        .b_i       (b),
        .acc_nxt_o (acc_nxt)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        product_d = product_q;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state_q)
            IDLE: begin
                load    = start;
                count_d = '0;
                state_d = start ? RUN : IDLE;
            end
            RUN: begin
                step    = 1'b1;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    product_d = acc_nxt;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs come straight from flops so they stay stable through the clk-high phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= state_d != IDLE;
            done_q    <= state_d == DONE;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: random and directed stimulus with a queue scoreboard against a plain a*b timing model.
module tb_seq_multiplier;
    localparam int WIDTH = 16;

    typedef struct {
        logic [2*WIDTH-1:0] p;
        int                 due;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [WIDTH-1:0]   a = '0;
    logic [WIDTH-1:0]   b = '0;
    logic               busy, done;
    logic [2*WIDTH-1:0] product;

    exp_t               q[$];
    int                 cyc = 0;
    int                 next_free = 0;
    logic [2*WIDTH-1:0] last_prod = '0;
    int                 total = 0;
    int                 bad = 0;

    seq_multiplier dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    // Reference: a start seen while free is accepted; result appears WIDTH edges later,
    // and the unit is free again two edges after that.
    always @(posedge clk) begin
        cyc++;
        if (rst_n && start && cyc >= next_free) begin
            q.push_back('{p: (2*WIDTH)'(a) * (2*WIDTH)'(b), due: cyc + WIDTH});
            next_free = cyc + WIDTH + 2;
        end
    end

    always @(negedge rst_n) begin
        q.delete();
        next_free = 0;
        last_prod = '0;
    end

    always @(negedge clk) begin
        logic exp_done;
        logic exp_busy;
        exp_done = q.size() > 0 && q[0].due == cyc;
        exp_busy = cyc < next_free - 1;
        total++;
        if (done !== exp_done) begin
            bad++;
            $display("FAIL done cyc=%0d got=%b want=%b", cyc, done, exp_done);
        end
        if (exp_done) begin
            last_prod = q[0].p;
            void'(q.pop_front());
        end
        total++;
        if (product !== last_prod) begin
            bad++;
            $display("FAIL product cyc=%0d got=%h want=%h", cyc, product, last_prod);
        end
        total++;
        if (busy !== exp_busy) begin
            bad++;
            $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy);
        end
    end

    task automatic go(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain timeout pending=%0d want=0", q.size());
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic async_reset_check();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
            bad++;
            $display("FAIL async_reset got busy=%b done=%b product=%h want 0 0 0", busy, done, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        go(16'd3, 16'd5);
        drain();
        async_reset_check();
        go(16'hFFFF, 16'hFFFF);
        drain();
        go(16'h1234, 16'h0000);
        drain();
        go(16'h0000, 16'hBEEF);
        drain();
        go(16'd3, 16'd5);
        repeat (4) @(negedge clk);
        go(16'd7, 16'd7);
        drain();
        go(16'd3, 16'd5);
        repeat (7) @(negedge clk);
        async_reset_check();
        go(16'd2, 16'd9);
        drain();
        @(negedge clk);
        a = 16'd10;
        b = 16'd10;
        start = 1'b1;
        repeat (60) @(negedge clk);
        start = 1'b0;
        drain();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start = $urandom_range(0, 3) == 0;
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
        end
        start = 1'b0;
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
